xgriscv_if_stage: RTL and testbench

//   Instruction-fetch stage and IF/ID pipeline register for the xgriscv pipelined core.
//   - Owns the architectural fetch PC and drives the word address into the instruction ROM (U_imem).
//   - Captures the ROM word, with its PC and PC+4, into the IF/ID register consumed by decode.
//   - Honours stall, flush and branch/jump redirect from the hazard unit and EX stage.

---
 rtl/xgriscv_if_stage.sv | 130 +++++++++++++
 tb/tb_xgriscv_if_stage.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/xgriscv_if_stage.sv
// Instruction-fetch stage for the xgriscv pipelined core: owns the fetch PC,
// addresses the instruction ROM and loads the IF/ID register handed to decode.
module xgriscv_if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 10,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               stallF,
  input  logic               flushD,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pcF,
  output logic [31:0]        instrD,
  output logic [31:0]        pcD,
  output logic [31:0]        pc_plus4D,
  output logic               validD,
  output logic               misalignD,
  output logic [31:0]        fetch_cnt
);

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic [31:0] pcd_next;
  logic [31:0] pc4_next;
  logic        valid_next;
  logic        misalign_next;
  logic [31:0] cnt_next;

  // Sequential PC advance; wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // The ROM is word addressed and aliases above its size.
  assign imem_addr = pcF[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Redirect wins over stall so a resolved branch is never lost.
  always_comb begin
    pc_next = pcF;
    if (state == RUN) begin
      if (redirect_valid) begin
        pc_next = redirect_pc;
      end else if (!stallF) begin
        pc_next = pc_inc(pcF);
      end
    end
  end

  always_comb begin
    instr_next    = instrD;
    pcd_next      = pcD;
    pc4_next      = pc_plus4D;
    valid_next    = validD;
    misalign_next = misalignD;
    cnt_next      = fetch_cnt;
    if (state == BOOT || flushD) begin
      // BOOT gives the ROM one settling cycle; flush squashes the slot.
      instr_next    = NOP_INSTR;
      valid_next    = 1'b0;
      misalign_next = 1'b0;
    end else if (!stallF) begin
      if (pcF[1:0] != 2'b00) begin
        instr_next    = NOP_INSTR;
        pcd_next      = pcF;
        valid_next    = 1'b0;
        misalign_next = 1'b1;
      end else begin
        instr_next    = imem_rdata;
        pcd_next      = pcF;
        pc4_next      = pc_inc(pcF);
        valid_next    = 1'b1;
        misalign_next = 1'b0;
        cnt_next      = sat_inc(fetch_cnt);
      end
    end
  end

  // Fetch PC / IF-ID register boundary
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pcF       <= RESET_PC;
      instrD    <= NOP_INSTR;
      pcD       <= 32'd0;
      pc_plus4D <= 32'd0;
      validD    <= 1'b0;
      misalignD <= 1'b0;
      fetch_cnt <= 32'd0;
    end else begin
      pcF       <= pc_next;
      instrD    <= instr_next;
      pcD       <= pcd_next;
      pc_plus4D <= pc4_next;
      validD    <= valid_next;
      misalignD <= misalign_next;
      fetch_cnt <= cnt_next;
    end
  end

endmodule

// File: tb/tb_xgriscv_if_stage.sv
// Bench for xgriscv_if_stage: directed vector table for the fetch scenarios,
// then randomized traffic against a behavioural model of the fetch rules.
module tb_xgriscv_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rstn;
  logic        stallF;
  logic        flushD;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pcF;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic [31:0] pc_plus4D;
  logic        validD;
  logic        misalignD;
  logic [31:0] fetch_cnt;

  logic [31:0] rom [0:1023];
  assign imem_rdata = rom[imem_addr];

  xgriscv_if_stage dut (
    .clk            (clk),
    .rstn           (rstn),
    .stallF         (stallF),
    .flushD         (flushD),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .pcF            (pcF),
    .instrD         (instrD),
    .pcD            (pcD),
    .pc_plus4D      (pc_plus4D),
    .validD         (validD),
    .misalignD      (misalignD),
    .fetch_cnt      (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic [31:0] e_pcd;
    logic [31:0] e_pc4;
    logic        e_valid;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [15];

  // Behavioural model state
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_valid, m_mis, m_run;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                           input logic [31:0] e_pcd, input logic [31:0] e_pc4, input logic e_valid,
                           input logic e_mis, input logic [31:0] e_cnt);
    chk32({tag, " pcF"}, pcF, e_pc);
    chk32({tag, " instrD"}, instrD, e_instr);
    chk32({tag, " pcD"}, pcD, e_pcd);
    chk32({tag, " pc_plus4D"}, pc_plus4D, e_pc4);
    chk1({tag, " validD"}, validD, e_valid);
    chk1({tag, " misalignD"}, misalignD, e_mis);
    chk32({tag, " fetch_cnt"}, fetch_cnt, e_cnt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_instr = NOP; m_pcd = 32'd0; m_pc4 = 32'd0;
    m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'd0; m_run = 1'b0;
  endtask

  // One rising edge of the fetch rules, using plain arithmetic on the model PC.
  task automatic model_edge(input logic s, input logic f, input logic r, input logic [31:0] rpc);
    longint unsigned pc_now;
    pc_now = longint'(m_pc);
    if (!m_run) begin
      m_run = 1'b1; m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
      return;
    end
    if (f) begin
      m_instr = NOP; m_valid = 1'b0; m_mis = 1'b0;
    end else if (!s) begin
      if (pc_now % 4 != 0) begin
        m_instr = NOP; m_valid = 1'b0; m_mis = 1'b1; m_pcd = m_pc;
      end else begin
        m_instr = rom[(pc_now / 4) % 1024];
        m_pcd   = m_pc;
        m_pc4   = 32'((pc_now + 4) % 64'h1_0000_0000);
        m_valid = 1'b1; m_mis = 1'b0;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end
    end
    if (r) m_pc = rpc;
    else if (!s) m_pc = 32'((pc_now + 4) % 64'h1_0000_0000);
  endtask

  initial begin
    //            stall  flush  redir  rpc           pc            instr         pcD           pc4           v      m      cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        NOP,          32'h0,        32'h0,        1'b0, 1'b0, 32'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0, 32'd1};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0, 32'd2};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h8,        32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0, 32'd2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'hC,        32'h002081b3, 32'h8,        32'hC,        1'b1, 1'b0, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h10,       32'h0000006f, 32'hC,        32'h10,       1'b1, 1'b0, 32'd4};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h20,       32'h20,       NOP,          32'hC,        32'h10,       1'b0, 1'b0, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h24,       32'hC0000008, 32'h20,       32'h24,       1'b1, 1'b0, 32'd5};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'h22,       32'h22,       32'hC0000009, 32'h24,       32'h28,       1'b1, 1'b0, 32'd6};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h26,       NOP,          32'h22,       32'h28,       1'b0, 1'b1, 32'd6};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, NOP,          32'h26,       32'h28,       1'b0, 1'b1, 32'd6};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        32'hC00003FF, 32'hFFFFFFFC, 32'h0,        1'b1, 1'b0, 32'd7};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,        32'h00500093, 32'h0,        32'h4,        1'b1, 1'b0, 32'd8};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 32'h14,       32'h14,       32'h00100113, 32'h4,        32'h8,        1'b1, 1'b0, 32'd9};

    for (int i = 0; i < 1024; i++) rom[i] = 32'hC000_0000 | 32'(i);
    rom[0] = 32'h00500093; rom[1] = 32'h00100113; rom[2] = 32'h002081b3; rom[3] = 32'h0000006f;

    rstn = 1'b0; stallF = 1'b0; flushD = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #20;
    check_all("reset", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    rstn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      stallF = vecs[i].stall; flushD = vecs[i].flush;
      redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
      tick();
      check_all($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_instr, vecs[i].e_pcd,
                vecs[i].e_pc4, vecs[i].e_valid, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Asynchronous reset while pcF=0x14, then BOOT must be re-entered.
    stallF = 1'b0; flushD = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    #2 rstn = 1'b0;
    #1;
    check_all("midreset", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    #2 rstn = 1'b1;
    tick();
    check_all("reboot", 32'h0, NOP, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0);
    tick();
    check_all("refetch", 32'h4, 32'h00500093, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    #2 rstn = 1'b0;
    model_reset();
    #2 rstn = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic s, f, r;
      logic [31:0] rpc;
      if ($urandom_range(0, 249) == 0) begin
        rstn = 1'b0;
        #1;
        model_reset();
        check_all("rnd_reset", m_pc, m_instr, m_pcd, m_pc4, m_valid, m_mis, m_cnt);
        #1 rstn = 1'b1;
      end
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 6) == 0);
      r = ($urandom_range(0, 6) == 0);
      case ($urandom_range(0, 3))
        0:       rpc = $urandom;
        1:       rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2:       rpc = 32'($urandom_range(0, 255));
        default: rpc = 32'($urandom_range(0, 63)) * 32'd4;
      endcase
      stallF = s; flushD = f; redirect_valid = r; redirect_pc = rpc;
      model_edge(s, f, r, rpc);
      tick();
      check_all($sformatf("rnd%0d", cyc), m_pc, m_instr, m_pcd, m_pc4, m_valid, m_mis, m_cnt);
      chk32($sformatf("rnd%0d imem_addr", cyc), {22'd0, imem_addr}, (m_pc / 32'd4) % 32'd1024);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
